// File: rtl/divider_8by4_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider. It produces one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to finish a zero-divisor request after one cycle and raise div_by_zero.
module divider_8by4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [7:0] dvd_sh;
  logic [3:0] dvs;
  logic [3:0] part;
  logic [7:0] q_acc;
  logic [2:0] count;

  logic [4:0] shifted;
  logic [3:0] part_next;
  logic       q_bit;

  // One restoring step. The 5-bit shifted value can reach 2*divisor-1, so
  // the compare needs the extra bit. The stored remainder always fits in 4 bits.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    shifted   = {part, dvd_sh[7]};
    q_bit     = 1'b0;
    part_next = shifted[3:0];
    if (shifted >= {1'b0, dvs}) begin
      q_bit     = 1'b1;
      part_next = 4'(shifted - {1'b0, dvs});
    end
  end

`ifndef DIV_ZERO_DETECT_EN
  assign div_by_zero = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= 8'h00;
      remainder <= 4'h0;
      dvd_sh    <= 8'h00;
      dvs       <= 4'h0;
      part      <= 4'h0;
      q_acc     <= 8'h00;
      count     <= 3'd0;
`ifdef DIV_ZERO_DETECT_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != CALC && start) begin
        // Capture the operands here. Inputs can change freely while CALC runs.
        state  <= CALC;
        busy   <= 1'b1;
        dvd_sh <= dividend;
        dvs    <= divisor;
        part   <= 4'h0;
        q_acc  <= 8'h00;
        count  <= 3'd0;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (state == CALC) begin
`ifdef DIV_ZERO_DETECT_EN
        if (dvs == 4'h0) begin
          // This gives the same result that the full restoring sequence would produce.
          state       <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
          quotient    <= 8'hFF;
          remainder   <= dvd_sh[3:0];
          div_by_zero <= 1'b1;
        end else begin
`else
        begin
`endif
          dvd_sh <= {dvd_sh[6:0], 1'b0};
          part   <= part_next;
          q_acc  <= {q_acc[6:0], q_bit};
          count  <= count + 3'd1;
          if (count == 3'd7) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {q_acc[6:0], q_bit};
            remainder <= part_next;
`ifdef DIV_ZERO_DETECT_EN
            div_by_zero <= 1'b0;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_8by4_seq.sv
// Directed self-checking bench for divider_8by4_seq. A queue-based scoreboard tracks expected results.
module tb_divider_8by4_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [3:0] divisor = 4'h0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy, done, div_by_zero;

  divider_8by4_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         k = 0;
  logic [7:0] last_q = 8'h00;
  logic [3:0] last_r = 4'h0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'h0) begin
      e.q = 8'hFF;
      e.r = a[3:0];
    end else begin
      e.q = a / {4'h0, b};
      e.r = 4'(a % {4'h0, b});
    end
    e.dbz = 1'b0;
    e.lat = 9;
`ifdef DIV_ZERO_DETECT_EN
    if (b == 4'h0) begin
      e.dbz = 1'b1;
      e.lat = 2;
    end
`endif
    return e;
  endfunction

  // Call this at a negedge. It returns at the first negedge after the accepting edge (k = 1).
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check("busy_after_accept", 16'(busy), 16'h1);
    check("q_hold_calc", 16'(quotient), 16'(last_q));
    check("r_hold_calc", 16'(remainder), 16'(last_r));
  endtask

  task automatic wait_done();
    exp_t e;
    while (!done && k < 20) begin
      check("busy_in_calc", 16'(busy), 16'h1);
      @(negedge clk);
      k++;
    end
    check("done_seen", 16'(done), 16'h1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", 16'(k), 16'(e.lat));
      check("quotient", 16'(quotient), 16'(e.q));
      check("remainder", 16'(remainder), 16'(e.r));
      check("div_by_zero", 16'(div_by_zero), 16'(e.dbz));
      check("busy_at_done", 16'(busy), 16'h0);
      last_q = e.q;
      last_r = e.r;
    end
  endtask

  task automatic after_done_idle();
    @(negedge clk);
    check("done_one_cycle", 16'(done), 16'h0);
    check("busy_idle", 16'(busy), 16'h0);
    check("q_hold_idle", 16'(quotient), 16'(last_q));
  endtask

  initial begin
    #1;
    check("rst_quotient", 16'(quotient), 16'h00);
    check("rst_remainder", 16'(remainder), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_dbz", 16'(div_by_zero), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(8'd144, 4'd12);
    wait_done();
    after_done_idle();

    launch(8'd200, 4'd13);
    wait_done();
    after_done_idle();

    // Back-to-back: the second start arrives during the DONE cycle.
    launch(8'd255, 4'd15);
    wait_done();
    launch(8'd90, 4'd6);
    wait_done();
    after_done_idle();

    // A start pulse in the third CALC cycle must be ignored.
    launch(8'd100, 4'd7);
    @(negedge clk); k++;
    @(negedge clk); k++;
    start = 1'b1; dividend = 8'd7; divisor = 4'd1;
    @(negedge clk); k++;
    start = 1'b0;
    wait_done();
    after_done_idle();

    launch(8'd77, 4'd0);
    wait_done();
    after_done_idle();

    // Reset in the fourth CALC cycle aborts the division and clears the outputs immediately.
    launch(8'd200, 4'd13);
    repeat (3) begin @(negedge clk); k++; end
    #2 rst_n = 1'b0;
    #1;
    check("abort_quotient", 16'(quotient), 16'h00);
    check("abort_remainder", 16'(remainder), 16'h0);
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_done", 16'(done), 16'h0);
    check("abort_dbz", 16'(div_by_zero), 16'h0);
    void'(sb.pop_front());
    last_q = 8'h00;
    last_r = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 16'(done), 16'h0);
    end

    launch(8'd250, 4'd9);
    wait_done();
    after_done_idle();

    for (int i = 0; i < 6; i++) begin
      launch(8'($urandom_range(255)), 4'($urandom_range(15)));
      wait_done();
      after_done_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
